// File: rtl/bank_pkg.sv
// -----------------------------------------------------------------------------
// bank_pkg
// Shared definitions for the bank issue scheduler slice: default issue-queue
// index width, default downstream credit count, the credit counter width
// helper and the issue FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package bank_pkg;

    localparam int ISU_PTR_WIDH   = 6;
    localparam int ISU_CREDIT_MAX = 4;

    // The credit counter is one bit wider than an entry index so it can hold
    // any credit budget up to the queue depth itself.
    function automatic int isu_credit_w(input int ptr_w);
        return ptr_w + 1;
    endfunction

    typedef enum logic {
        ISU_IDLE = 1'b0,
        ISU_REQ  = 1'b1
    } isu_state_e;

endpackage

// File: rtl/bank_isu_sched_if.sv
// -----------------------------------------------------------------------------
// bank_isu_sched_if
// Bundles the scheduler's upstream (allocate / wake / head) and downstream
// (issue handshake / credit return) signals.
//   master : the issue queue and downstream pipeline around the scheduler
//   slave  : the scheduler itself
// Parameter PTR_WIDH sets the entry index width; DEPTH = 1 << PTR_WIDH.
// -----------------------------------------------------------------------------
interface bank_isu_sched_if #(
    parameter int PTR_WIDH = bank_pkg::ISU_PTR_WIDH
);
    import bank_pkg::*;

    localparam int DEPTH = 1 << PTR_WIDH;
    localparam int CNT_W = isu_credit_w(PTR_WIDH);

    logic                alloc_valid_i;
    logic [PTR_WIDH-1:0] alloc_ptr_i;
    logic                alloc_ready_i;
    logic [DEPTH-1:0]    wake_mask_i;
    logic [PTR_WIDH-1:0] head_ptr_i;
    logic                credit_return_i;
    logic                issue_valid_o;
    logic [PTR_WIDH-1:0] issue_ptr_o;
    logic                issue_ready_i;
    logic [CNT_W-1:0]    credit_cnt_o;
    logic                busy_o;

    modport master (
        output alloc_valid_i, alloc_ptr_i, alloc_ready_i, wake_mask_i,
               head_ptr_i, credit_return_i, issue_ready_i,
        input  issue_valid_o, issue_ptr_o, credit_cnt_o, busy_o
    );

    modport slave (
        input  alloc_valid_i, alloc_ptr_i, alloc_ready_i, wake_mask_i,
               head_ptr_i, credit_return_i, issue_ready_i,
        output issue_valid_o, issue_ptr_o, credit_cnt_o, busy_o
    );

endinterface

// File: rtl/bank_isu_pick.sv
// -----------------------------------------------------------------------------
// bank_isu_pick
// Combinational round-robin style picker: returns the first set bit of mask_i
// found when scanning upward from base_i, wrapping from DEPTH-1 back to 0.
// A base of zero degenerates to a plain lowest-index pick.
// Ports:
//   mask_i   in  DEPTH     candidate entries
//   base_i   in  PTR_WIDH  scan start index
//   onehot_o out DEPTH     selected entry as a one-hot vector
//   idx_o    out PTR_WIDH  selected entry index
//   found_o  out 1         any candidate present
// -----------------------------------------------------------------------------
module bank_isu_pick #(
    parameter int PTR_WIDH = bank_pkg::ISU_PTR_WIDH,
    localparam int DEPTH   = 1 << PTR_WIDH
) (
    input  logic [DEPTH-1:0]    mask_i,
    input  logic [PTR_WIDH-1:0] base_i,
    output logic [DEPTH-1:0]    onehot_o,
    output logic [PTR_WIDH-1:0] idx_o,
    output logic                found_o
);

    logic [PTR_WIDH-1:0] scan_idx;

    // DEPTH is a power of two, so letting the PTR_WIDH-bit sum overflow gives
    // the wrap from DEPTH-1 back to 0 for free.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = base_i + PTR_WIDH'(i);
            if (!found_o && mask_i[scan_idx]) begin
                found_o = 1'b1;
                idx_o   = scan_idx;
            end
        end
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/bank_isu_sched.sv
// -----------------------------------------------------------------------------
// bank_isu_sched
// Issue scheduler for a bank issue queue. Tracks which entries are allocated
// (pend) and allowed by the MSHR (rdy), selects one eligible entry at a time,
// presents it downstream with a valid/ready handshake and spends one pipeline
// credit per accepted issue.
// Ports:
//   clk_i  in  clock
//   rst_i  in  asynchronous active-high reset
//   bus    bank_isu_sched_if.slave (alloc/wake/head in, issue handshake,
//          credit return, credit count and busy out)
// Parameters: PTR_WIDH (index width, DEPTH = 1 << PTR_WIDH), CREDIT_MAX.
// Configuration macro BANK_ISU_SCHED_AGE_PRIO_EN: when defined, selection
// starts at head_ptr_i (oldest first, wrapping); otherwise lowest index wins.
// -----------------------------------------------------------------------------
module bank_isu_sched #(
    parameter int PTR_WIDH   = bank_pkg::ISU_PTR_WIDH,
    parameter int CREDIT_MAX = bank_pkg::ISU_CREDIT_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bank_isu_sched_if.slave   bus
);
    import bank_pkg::*;

    localparam int DEPTH = 1 << PTR_WIDH;
    localparam int CNT_W = isu_credit_w(PTR_WIDH);

    logic [DEPTH-1:0]    pend_q, rdy_q, pend_d, rdy_d;
    logic [DEPTH-1:0]    held_oh_q;
    logic [DEPTH-1:0]    elig;
    logic [DEPTH-1:0]    pick_oh;
    logic [PTR_WIDH-1:0] pick_idx, pick_base;
    logic                pick_found;
    logic [PTR_WIDH-1:0] issue_ptr_q;
    logic                issue_valid_q;
    logic [CNT_W-1:0]    credit_q;
    logic                accept;
    isu_state_e          state_q;

    assign accept = issue_valid_q & bus.issue_ready_i;

    // The entry already being offered downstream must not be picked again
    // while its request is outstanding.
    assign elig = pend_q & rdy_q & ~held_oh_q;

`ifdef BANK_ISU_SCHED_AGE_PRIO_EN
    assign pick_base = bus.head_ptr_i;
`else
    assign pick_base = '0;
`endif

    bank_isu_pick #(
        .PTR_WIDH (PTR_WIDH)
    ) u_pick (
        .mask_i   (elig),
        .base_i   (pick_base),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Next entry state. Order matters: the accept clear comes first so that a
    // same-cycle allocate or wake of the accepted entry wins over it. A wake
    // only counts for entries that are already pending.
    always_comb begin
        pend_d = pend_q;
        rdy_d  = rdy_q;
        if (accept) begin
            pend_d = pend_d & ~held_oh_q;
            rdy_d  = rdy_d  & ~held_oh_q;
        end
        rdy_d = rdy_d | (bus.wake_mask_i & pend_q);
        if (bus.alloc_valid_i) begin
            pend_d[bus.alloc_ptr_i] = 1'b1;
            rdy_d[bus.alloc_ptr_i]  = bus.alloc_ready_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            rdy_q  <= '0;
        end else begin
            pend_q <= pend_d;
            rdy_q  <= rdy_d;
        end
    end

    // Issue FSM. The selected index is captured on entry to REQ and held
    // until downstream accepts, giving a one-cycle select latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ISU_IDLE;
            issue_valid_q <= 1'b0;
            issue_ptr_q   <= '0;
            held_oh_q     <= '0;
        end else begin
            case (state_q)
                ISU_IDLE: begin
                    if (pick_found && (credit_q != '0)) begin
                        state_q       <= ISU_REQ;
                        issue_valid_q <= 1'b1;
                        issue_ptr_q   <= pick_idx;
                        held_oh_q     <= pick_oh;
                    end
                end
                ISU_REQ: begin
                    if (bus.issue_ready_i) begin
                        state_q       <= ISU_IDLE;
                        issue_valid_q <= 1'b0;
                        held_oh_q     <= '0;
                    end
                end
            endcase
        end
    end

    // Credits: an accept spends one, a return refunds one, both together
    // cancel out, and a refund beyond the budget is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= CNT_W'(CREDIT_MAX);
        end else begin
            case ({accept, bus.credit_return_i})
                2'b10:   credit_q <= credit_q - CNT_W'(1);
                2'b01: begin
                    if (credit_q != CNT_W'(CREDIT_MAX)) begin
                        credit_q <= credit_q + CNT_W'(1);
                    end
                end
                default: credit_q <= credit_q;
            endcase
        end
    end

    assign bus.issue_valid_o = issue_valid_q;
    assign bus.issue_ptr_o   = issue_ptr_q;
    assign bus.credit_cnt_o  = credit_q;
    assign bus.busy_o        = |pend_q;

endmodule

// File: tb/tb_bank_isu_sched.sv
// -----------------------------------------------------------------------------
// tb_bank_isu_sched
// Directed self-checking bench for bank_isu_sched (PTR_WIDH=6, CREDIT_MAX=4).
// Inputs change one time unit after each rising edge; outputs are checked at
// that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_bank_isu_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bank_isu_sched_if #(.PTR_WIDH(6)) bus ();

    bank_isu_sched #(
        .PTR_WIDH   (6),
        .CREDIT_MAX (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid_i   = 1'b0;
        bus.alloc_ptr_i     = '0;
        bus.alloc_ready_i   = 1'b0;
        bus.wake_mask_i     = '0;
        bus.head_ptr_i      = '0;
        bus.credit_return_i = 1'b0;
        bus.issue_ready_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [5:0] ptr, input logic ready);
        bus.alloc_valid_i = 1'b1;
        bus.alloc_ptr_i   = ptr;
        bus.alloc_ready_i = ready;
        tick();
        bus.alloc_valid_i = 1'b0;
        bus.alloc_ready_i = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.credit_cnt_o !== 7'd4) begin n_fail++;
            $display("[TB] FAIL reset_credit: got %0d expected 4", bus.credit_cnt_o); end
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.issue_valid_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
        n_checks++; if (bus.issue_ptr_o !== 6'd0) begin n_fail++;
            $display("[TB] FAIL reset_ptr: got %0d expected 0", bus.issue_ptr_o); end
    endtask

    // Ready entry issues one cycle after allocation and is held until accepted.
    task automatic test_single_issue();
        do_reset();
        alloc(6'd3, 1'b1);
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL single_early_valid: got %b expected 0", bus.issue_valid_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++;
            $display("[TB] FAIL single_busy: got %b expected 1", bus.busy_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'd3) begin n_fail++;
                $display("[TB] FAIL single_hold%0d: got valid=%b ptr=%0d expected valid=1 ptr=3",
                         i, bus.issue_valid_o, bus.issue_ptr_o); end
            if (i < 3) tick();
        end
        bus.issue_ready_i = 1'b1;
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL single_drop_valid: got %b expected 0", bus.issue_valid_o); end
        n_checks++; if (bus.credit_cnt_o !== 7'd3) begin n_fail++;
            $display("[TB] FAIL single_credit: got %0d expected 3", bus.credit_cnt_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL single_busy_clear: got %b expected 0", bus.busy_o); end
    endtask

    // Entry allocated not-ready issues only after its wake bit arrives.
    task automatic test_wake();
        do_reset();
        alloc(6'd5, 1'b0);
        tick();
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL wake_prewake_valid: got %b expected 0", bus.issue_valid_o); end
        bus.wake_mask_i[5] = 1'b1;
        tick();
        bus.wake_mask_i = '0;
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL wake_edge_valid: got %b expected 0", bus.issue_valid_o); end
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'd5) begin n_fail++;
            $display("[TB] FAIL wake_issue: got valid=%b ptr=%0d expected valid=1 ptr=5",
                     bus.issue_valid_o, bus.issue_ptr_o); end
        bus.issue_ready_i = 1'b1;
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd3) begin n_fail++;
            $display("[TB] FAIL wake_credit: got %0d expected 3", bus.credit_cnt_o); end
    endtask

    // A wake for a non-pending entry must not stick to a later allocation.
    task automatic test_wake_ignored();
        do_reset();
        bus.wake_mask_i[9] = 1'b1;
        tick();
        bus.wake_mask_i = '0;
        alloc(6'd9, 1'b0);
        tick();
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL wake_ignored_valid: got %b expected 0", bus.issue_valid_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++;
            $display("[TB] FAIL wake_ignored_busy: got %b expected 1", bus.busy_o); end
    endtask

    // Re-allocating a pending entry overwrites its ready bit.
    task automatic test_overwrite();
        do_reset();
        alloc(6'd8, 1'b0);
        alloc(6'd8, 1'b1);
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL overwrite_early: got %b expected 0", bus.issue_valid_o); end
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'd8) begin n_fail++;
            $display("[TB] FAIL overwrite_issue: got valid=%b ptr=%0d expected valid=1 ptr=8",
                     bus.issue_valid_o, bus.issue_ptr_o); end
    endtask

    // Head at 62 with entries 1 and 63 eligible: order depends on build.
    task automatic test_age_prio();
        logic [5:0] exp_first;
        logic [5:0] exp_second;
`ifdef BANK_ISU_SCHED_AGE_PRIO_EN
        exp_first  = 6'd63;
        exp_second = 6'd1;
`else
        exp_first  = 6'd1;
        exp_second = 6'd63;
`endif
        do_reset();
        bus.head_ptr_i = 6'd62;
        alloc(6'd1, 1'b0);
        alloc(6'd63, 1'b0);
        bus.wake_mask_i[1]  = 1'b1;
        bus.wake_mask_i[63] = 1'b1;
        tick();
        bus.wake_mask_i = '0;
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== exp_first) begin n_fail++;
            $display("[TB] FAIL age_first: got valid=%b ptr=%0d expected valid=1 ptr=%0d",
                     bus.issue_valid_o, bus.issue_ptr_o, exp_first); end
        bus.issue_ready_i = 1'b1;
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL age_gap: got %b expected 0", bus.issue_valid_o); end
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== exp_second) begin n_fail++;
            $display("[TB] FAIL age_second: got valid=%b ptr=%0d expected valid=1 ptr=%0d",
                     bus.issue_valid_o, bus.issue_ptr_o, exp_second); end
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd2 || bus.busy_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL age_done: got credit=%0d busy=%b expected credit=2 busy=0",
                     bus.credit_cnt_o, bus.busy_o); end
    endtask

    // Credits run out after four accepts; a return lets the fifth issue.
    task automatic test_credit_exhaust();
        do_reset();
        for (int i = 10; i < 15; i++) alloc(6'(i), 1'b0);
        bus.wake_mask_i = 64'h0000_0000_0000_7C00;
        tick();
        bus.wake_mask_i = '0;
        bus.issue_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'(10 + i)) begin n_fail++;
                $display("[TB] FAIL credit_issue%0d: got valid=%b ptr=%0d expected valid=1 ptr=%0d",
                         i, bus.issue_valid_o, bus.issue_ptr_o, 10 + i); end
            tick();
            n_checks++; if (bus.credit_cnt_o !== 7'(3 - i)) begin n_fail++;
                $display("[TB] FAIL credit_count%0d: got %0d expected %0d", i, bus.credit_cnt_o, 3 - i); end
        end
        tick();
        tick();
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_fail++;
            $display("[TB] FAIL credit_starved: got valid=%b busy=%b expected valid=0 busy=1",
                     bus.issue_valid_o, bus.busy_o); end
        bus.credit_return_i = 1'b1;
        tick();
        bus.credit_return_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd1 || bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL credit_returned: got credit=%0d valid=%b expected credit=1 valid=0",
                     bus.credit_cnt_o, bus.issue_valid_o); end
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'd14) begin n_fail++;
            $display("[TB] FAIL credit_fifth: got valid=%b ptr=%0d expected valid=1 ptr=14",
                     bus.issue_valid_o, bus.issue_ptr_o); end
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd0 || bus.busy_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL credit_final: got credit=%0d busy=%b expected credit=0 busy=0",
                     bus.credit_cnt_o, bus.busy_o); end
    endtask

    // Return coincident with accept cancels; returns saturate at the maximum.
    task automatic test_credit_coincident();
        do_reset();
        for (int i = 20; i < 23; i++) alloc(6'(i), 1'b0);
        bus.wake_mask_i = 64'h0000_0000_0070_0000;
        tick();
        bus.wake_mask_i = '0;
        bus.issue_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.credit_cnt_o !== 7'd2) begin n_fail++;
            $display("[TB] FAIL coinc_setup: got valid=%b credit=%0d expected valid=1 credit=2",
                     bus.issue_valid_o, bus.credit_cnt_o); end
        bus.credit_return_i = 1'b1;
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd2 || bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL coinc_cancel: got credit=%0d valid=%b expected credit=2 valid=0",
                     bus.credit_cnt_o, bus.issue_valid_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.credit_cnt_o !== 7'((i < 2) ? 3 + i : 4)) begin n_fail++;
                $display("[TB] FAIL coinc_return%0d: got %0d expected %0d",
                         i, bus.credit_cnt_o, (i < 2) ? 3 + i : 4); end
        end
        bus.credit_return_i = 1'b0;
    endtask

    // Accepting an entry while it is re-allocated keeps it pending and it
    // issues again; back-to-back issues of the same index.
    task automatic test_back_to_back();
        do_reset();
        alloc(6'd30, 1'b1);
        tick();
        bus.issue_ready_i = 1'b1;
        alloc(6'd30, 1'b1);
        n_checks++; if (bus.issue_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.credit_cnt_o !== 7'd3) begin n_fail++;
            $display("[TB] FAIL b2b_realloc: got valid=%b busy=%b credit=%0d expected valid=0 busy=1 credit=3",
                     bus.issue_valid_o, bus.busy_o, bus.credit_cnt_o); end
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1 || bus.issue_ptr_o !== 6'd30) begin n_fail++;
            $display("[TB] FAIL b2b_reissue: got valid=%b ptr=%0d expected valid=1 ptr=30",
                     bus.issue_valid_o, bus.issue_ptr_o); end
        tick();
        bus.issue_ready_i = 1'b0;
        n_checks++; if (bus.credit_cnt_o !== 7'd2 || bus.busy_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL b2b_done: got credit=%0d busy=%b expected credit=2 busy=0",
                     bus.credit_cnt_o, bus.busy_o); end
    endtask

    // Asynchronous reset in the middle of a request aborts it immediately.
    task automatic test_reset_mid();
        do_reset();
        alloc(6'd7, 1'b1);
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b1) begin n_fail++;
            $display("[TB] FAIL rstmid_pre: got %b expected 1", bus.issue_valid_o); end
        rst = 1'b1;
        #2;
        n_checks++; if (bus.issue_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.credit_cnt_o !== 7'd4) begin n_fail++;
            $display("[TB] FAIL rstmid_abort: got valid=%b busy=%b credit=%0d expected valid=0 busy=0 credit=4",
                     bus.issue_valid_o, bus.busy_o, bus.credit_cnt_o); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.issue_valid_o !== 1'b0) begin n_fail++;
            $display("[TB] FAIL rstmid_after: got %b expected 0", bus.issue_valid_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_wake();
        test_wake_ignored();
        test_overwrite();
        test_age_prio();
        test_credit_exhaust();
        test_credit_coincident();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
